// File: rtl/lane_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lane_packer: packs WIDTH-bit items into N_LANE-lane words, early close on last
// Rev 1.0
// ---------------------------------------------------------------------------
module lane_packer #(
  parameter int WIDTH  = 8,
  parameter int N_LANE = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_cg,
  input  logic                               i_in_valid,
  output logic                               o_in_ready,
  input  logic [WIDTH-1:0]                   i_in_data,
  input  logic                               i_in_last,
  output logic                               o_out_valid,
  input  logic                               i_out_ready,
  output logic [N_LANE*WIDTH-1:0]            o_out_data,
  output logic [$clog2(N_LANE+1)-1:0]        o_out_count,
  output logic                               o_out_last
);

  localparam int CNT_W  = $clog2(N_LANE);
  localparam int OCNT_W = $clog2(N_LANE+1);
  localparam int WORD_W = N_LANE*WIDTH;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  slot_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  acc_q, acc_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic [OCNT_W-1:0]  count_q, count_d;
  logic               last_q, last_d;

  logic               w_accept;
  logic               w_complete;
  logic [WORD_W-1:0]  w_word;

  assign o_in_ready  = i_cg && ((state_q == EMPTY) || i_out_ready);
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_complete  = w_accept && ((cnt_q == CNT_W'(N_LANE-1)) || i_in_last);

  assign o_out_valid = (state_q == FULL);
  assign o_out_data  = data_q;
  assign o_out_count = count_q;
  assign o_out_last  = last_q;

  // Lanes above cnt are already zero because acc is cleared on every completion.
  always_comb begin
    w_word = acc_q;
    for (int l = 0; l < N_LANE; l++) begin
      if (cnt_q == CNT_W'(l)) begin
        w_word[l*WIDTH +: WIDTH] = i_in_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    count_d = count_q;
    last_d  = last_q;
    if (w_complete) begin
      data_d  = w_word;
      count_d = OCNT_W'(cnt_q) + OCNT_W'(1);
      last_d  = i_in_last;
      state_d = FULL;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      if (w_accept) begin
        acc_d = w_word;
        cnt_d = cnt_q + CNT_W'(1);
      end
      if ((state_q == FULL) && i_out_ready) begin
        state_d = EMPTY;
      end
    end
  end

  // Clock gate freezes every register, including the output slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else if (i_cg) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

endmodule
`default_nettype wire
